// File: rtl/edge_evt_pkg.sv
// Shared definitions for the edge event arbiter: default requester count,
// event-id width helper and the id type used by consumers of the channel.
package edge_evt_pkg;

  localparam int N_REQ_DEFAULT = 4;

  // Width of an index into n requesters; never narrower than one bit.
  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  typedef logic [id_width(N_REQ_DEFAULT)-1:0] evt_id_t;

endpackage

// File: rtl/rise_edge_sync.sv
// One-bit synchronizer for an asynchronous level input, with a single-cycle
// rise indication derived from the two settled stages.
module rise_edge_sync (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic rise
);

  logic sync1;
  logic sync2;
  logic sync3;

  // Stages 1-2 absorb metastability; stage 3 remembers the previous settled value.
  // NOTE: non-blocking assignments let each stage capture the previous stage's
  // pre-edge value, giving a true shift register regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      sync3 <= 1'b0;
    end else begin
      sync1 <= d;
      sync2 <= sync1;
      sync3 <= sync2;
    end
  end

  // sync3 clears in reset, so a level held high across reset release counts once.
  assign rise = sync2 & ~sync3;

endmodule

// File: rtl/edge_event_arbiter.sv
// Turns rising edges on N_REQ asynchronous level inputs into pending events and
// grants them one at a time, round-robin, onto a single valid/ready channel.
module edge_event_arbiter
  import edge_evt_pkg::*;
#(
  parameter  int N_REQ = N_REQ_DEFAULT,
  localparam int ID_W  = id_width(N_REQ)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] req_in,
  output logic             evt_valid,
  output logic [ID_W-1:0]  evt_id,
  input  logic             evt_ready,
  output logic [N_REQ-1:0] pend,
  output logic [N_REQ-1:0] overflow,
  input  logic             ovf_clr
);

  // Result of a round-robin search over the pending bits.
  typedef struct packed {
    logic            found;
    logic [ID_W-1:0] id;
  } pick_t;

  // First set bit of req, searching upward from start and wrapping at N_REQ.
  function automatic pick_t rr_pick(input logic [N_REQ-1:0] req,
                                    input logic [ID_W-1:0]  start);
    pick_t p;
    int    idx;
    p.found = 1'b0;
    p.id    = '0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = (int'(start) + k) % N_REQ;
      if (!p.found && req[idx]) begin
        p.found = 1'b1;
        p.id    = ID_W'(idx);
      end
    end
    return p;
  endfunction

  generate
    if (N_REQ < 2 || N_REQ > 16) begin : g_bad_param
      $error("edge_event_arbiter: N_REQ must be within 2..16");
    end
  endgenerate

  logic [N_REQ-1:0] rise;
  logic [N_REQ-1:0] grant;
  logic [N_REQ-1:0] ovf_set;
  logic [ID_W-1:0]  rr_ptr;
  logic [ID_W-1:0]  ptr_next;
  logic             load;
  pick_t            pick;

  for (genvar i = 0; i < N_REQ; i++) begin : g_sync
    rise_edge_sync u_sync (
      .clk  (clk),
      .rst  (rst),
      .d    (req_in[i]),
      .rise (rise[i])
    );
  end

  // The output register may take a new event when empty or being drained.
  assign load = !evt_valid || evt_ready;
  assign pick = rr_pick(pend, rr_ptr);
  assign ptr_next = (int'(pick.id) == N_REQ - 1) ? '0 : pick.id + 1'b1;

  // One-hot mask of the requester handed to the output register this cycle.
  // NOTE: the default assignment before the conditional keeps this purely
  // combinational; without it grant would need to hold and infer a latch.
  always_comb begin
    grant = '0;
    if (load && pick.found) begin
      grant[pick.id] = 1'b1;
    end
  end

  // A rise on a still-waiting, non-granted requester collapses into one event.
  assign ovf_set = rise & pend & ~grant;

  // Pending and sticky overflow bits; a fresh rise always re-arms pend, even
  // when the same requester is being granted, and a new overflow beats ovf_clr.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend     <= '0;
      overflow <= '0;
    end else begin
      pend     <= (pend & ~grant) | rise;
      overflow <= ovf_set | (ovf_clr ? '0 : overflow);
    end
  end

  // Output register and round-robin pointer; contents hold under backpressure.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      evt_valid <= 1'b0;
      evt_id    <= '0;
      rr_ptr    <= '0;
    end else if (load) begin
      if (pick.found) begin
        evt_valid <= 1'b1;
        evt_id    <= pick.id;
        rr_ptr    <= ptr_next;
      end else begin
        evt_valid <= 1'b0;
      end
    end
  end

endmodule
